// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/debug memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Starvation counter and cpu_hold register for the debug port.
// Only compiled when MEM_ARB_STARVE_HOLD_EN is defined.
`ifdef MEM_ARB_STARVE_HOLD_EN
module mem_arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lost_cycle,
  input  logic grant_done,
  output logic cpu_hold
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (grant_done) begin
      cnt_d  = '0;
      hold_d = 1'b0;
    end else if (lost_cycle) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_W'(STARVE_LIMIT)) hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign cpu_hold = hold_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU has absolute priority, debug port waits.
// Optional starvation hold enabled by MEM_ARB_STARVE_HOLD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_r_n,
  input  logic              cpu_w_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_r_n,
  output logic              mem_w_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              proto_err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  arb_state_e        state_q, state_d;
  logic              dbg_we_q, dbg_we_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] dbg_wdata_q, dbg_wdata_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              proto_err_q, proto_err_d;

  logic cpu_active;
  assign cpu_active = (cpu_r_n == STROBE_ON) || (cpu_w_n == STROBE_ON);

  // Memory port mux; reset forces the strobes off even if the CPU is active.
  always_comb begin
    mem_r_n   = STROBE_OFF;
    mem_w_n   = STROBE_OFF;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (rst_n) begin
      if (cpu_active) begin
        mem_r_n = cpu_r_n;
        mem_w_n = cpu_w_n;
      end else if (state_q == WAIT) begin
        mem_addr = dbg_addr_q;
        if (dbg_we_q) begin
          mem_wdata = dbg_wdata_q;
          mem_w_n   = STROBE_ON;
        end else begin
          mem_r_n = STROBE_ON;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dbg_we_d    = dbg_we_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_wdata_d = dbg_wdata_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    proto_err_d = proto_err_q | ((cpu_r_n == STROBE_ON) && (cpu_w_n == STROBE_ON));
    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          dbg_we_d    = dbg_we;
          dbg_addr_d  = dbg_addr;
          dbg_wdata_d = dbg_wdata;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (!cpu_active) begin
          if (!dbg_we_q) dbg_rdata_d = mem_rdata;
          dbg_ack_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dbg_we_q    <= dbg_we_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_wdata_q <= dbg_wdata_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign proto_err = proto_err_q;

`ifdef MEM_ARB_STARVE_HOLD_EN
  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .lost_cycle((state_q == WAIT) && cpu_active),
    .grant_done((state_q == WAIT) && !cpu_active),
    .cpu_hold  (cpu_hold)
  );
`else
  assign cpu_hold = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_r_n, cpu_w_n;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;
  logic       mem_r_n, mem_w_n;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       cpu_hold, proto_err;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_w_n === 1'b0) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_r_n(cpu_r_n), .cpu_w_n(cpu_w_n), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_r_n(mem_r_n), .mem_w_n(mem_w_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_w_n = 1'b0;
    tick();
    cpu_w_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_r_n = 1'b0; cpu_w_n = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    tick(); tick();
    checks++;
    if ({mem_r_n, mem_w_n} !== 2'b11) begin
      errors++; $display("FAIL reset_strobes: got %b expected 11", {mem_r_n, mem_w_n});
    end
    checks++;
    if ({dbg_ack, cpu_hold, proto_err} !== 3'b000 || dbg_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: ack/hold/err=%b rdata=%h expected 000/00",
                         {dbg_ack, cpu_hold, proto_err}, dbg_rdata);
    end
    cpu_r_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dbg_write();
    int wlow = 0;
    int ack_cyc = -1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 8'h5A;
    for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
      tick();
      if (mem_w_n === 1'b0) begin
        wlow++;
        checks++;
        if (mem_addr !== 8'h10 || mem_wdata !== 8'h5A) begin
          errors++; $display("FAIL dbg_write_bus: addr=%h data=%h expected 10/5a", mem_addr, mem_wdata);
        end
      end
      if (dbg_ack === 1'b1) begin
        ack_cyc = c;
        dbg_req = 1'b0;
      end
    end
    checks++;
    if (ack_cyc !== 2) begin
      errors++; $display("FAIL dbg_write_latency: ack at cycle %0d expected 2", ack_cyc);
    end
    checks++;
    if (wlow !== 1) begin
      errors++; $display("FAIL dbg_write_strobe: mem_w_n low %0d cycles expected 1", wlow);
    end
    tick();
    checks++;
    if (dbg_ack !== 1'b0) begin
      errors++; $display("FAIL dbg_ack_pulse: got %b expected 0", dbg_ack);
    end
    checks++;
    if (mem[8'h10] !== 8'h5A) begin
      errors++; $display("FAIL dbg_write_mem: got %h expected 5a", mem[8'h10]);
    end
  endtask

  task automatic test_cpu_priority();
    cpu_r_n = 1'b0; cpu_addr = 8'h03;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) dbg_addr = 8'h03;
      checks++;
      if (cpu_rdata !== 8'hC3 || mem_r_n !== 1'b0 || mem_addr !== 8'h03 || dbg_ack !== 1'b0) begin
        errors++; $display("FAIL cpu_priority c%0d: rdata=%h r_n=%b addr=%h ack=%b expected c3/0/03/0",
                           c, cpu_rdata, mem_r_n, mem_addr, dbg_ack);
      end
    end
    cpu_r_n = 1'b1;
    #1;
    checks++;
    if (mem_addr !== 8'h20 || mem_r_n !== 1'b0) begin
      errors++; $display("FAIL dbg_read_grant: addr=%h r_n=%b expected 20/0", mem_addr, mem_r_n);
    end
    tick();
    checks++;
    if (dbg_ack !== 1'b1 || dbg_rdata !== 8'h77) begin
      errors++; $display("FAIL dbg_read_ack: ack=%b rdata=%h expected 1/77", dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    tick(); tick();
    checks++;
    if (dbg_ack !== 1'b0 || dbg_rdata !== 8'h77) begin
      errors++; $display("FAIL dbg_rdata_hold: ack=%b rdata=%h expected 0/77", dbg_ack, dbg_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_data [3];
    int n = 0;
    int last = 0;
    exp_data[0] = 8'hA0; exp_data[1] = 8'hA1; exp_data[2] = 8'hA2;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h00;
    for (int c = 1; c <= 15 && n < 3; c++) begin
      tick();
      if (dbg_ack === 1'b1) begin
        checks++;
        if (dbg_rdata !== exp_data[n]) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", n, dbg_rdata, exp_data[n]);
        end
        checks++;
        if ((n == 0 && c != 2) || (n != 0 && c - last != 3)) begin
          errors++; $display("FAIL b2b_spacing%0d: ack at cycle %0d previous %0d", n, c, last);
        end
        last = c;
        n++;
        if (n < 3) dbg_addr = 8'(n);
        else       dbg_req = 1'b0;
      end
    end
    dbg_req = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d acks expected 3", n);
    end
    tick();
  endtask

  task automatic test_starve();
    logic exp_hold;
    cpu_r_n = 1'b0; cpu_addr = 8'h03;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h01;
    for (int c = 1; c <= 10; c++) begin
      tick();
`ifdef MEM_ARB_STARVE_HOLD_EN
      exp_hold = (c >= 5);
`else
      exp_hold = 1'b0;
`endif
      checks++;
      if (cpu_hold !== exp_hold || dbg_ack !== 1'b0) begin
        errors++; $display("FAIL starve_hold c%0d: hold=%b ack=%b expected %b/0", c, cpu_hold, dbg_ack, exp_hold);
      end
    end
    cpu_r_n = 1'b1;
    tick();
    checks++;
    if (dbg_ack !== 1'b1 || cpu_hold !== 1'b0 || dbg_rdata !== 8'hA1) begin
      errors++; $display("FAIL starve_release: ack=%b hold=%b rdata=%h expected 1/0/a1",
                         dbg_ack, cpu_hold, dbg_rdata);
    end
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_request();
    int acks = 0;
    cpu_r_n = 1'b0; cpu_addr = 8'h03;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h50; dbg_wdata = 8'hEE;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_r_n, mem_w_n, dbg_ack, cpu_hold, proto_err} !== 5'b11000 || dbg_rdata !== 8'h00) begin
      errors++; $display("FAIL midreq_reset_outputs: r/w/ack/hold/err=%b rdata=%h expected 11000/00",
                         {mem_r_n, mem_w_n, dbg_ack, cpu_hold, proto_err}, dbg_rdata);
    end
    dbg_req = 1'b0; cpu_r_n = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dbg_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL midreq_no_ack: got %0d acks expected 0", acks);
    end
    checks++;
    if (mem[8'h50] !== 8'h33) begin
      errors++; $display("FAIL midreq_mem: got %h expected 33", mem[8'h50]);
    end
  endtask

  task automatic test_proto_err();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL proto_initial: got %b expected 0", proto_err);
    end
    cpu_r_n = 1'b0; cpu_w_n = 1'b0; cpu_addr = 8'h40; cpu_wdata = 8'h11;
    #1;
    checks++;
    if ({mem_r_n, mem_w_n} !== 2'b00) begin
      errors++; $display("FAIL proto_forward: got %b expected 00", {mem_r_n, mem_w_n});
    end
    tick();
    cpu_r_n = 1'b1; cpu_w_n = 1'b1;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_set: got %b expected 1", proto_err);
    end
    tick(); tick(); tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL proto_reset: got %b expected 0", proto_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL proto_after_reset: got %b expected 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    cpu_write(8'h03, 8'hC3);
    cpu_write(8'h20, 8'h77);
    cpu_write(8'h00, 8'hA0);
    cpu_write(8'h01, 8'hA1);
    cpu_write(8'h02, 8'hA2);
    cpu_write(8'h50, 8'h33);
    cpu_write(8'h10, 8'h00);
    tick();
    test_dbg_write();
    test_cpu_priority();
    test_back_to_back();
    test_starve();
    test_reset_mid_request();
    test_proto_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
